ddr3_cmd_arb: RTL
=================

# ddr3_cmd_arb

Two-port command arbiter sharing the single DDR3 PHY command interface (and the read-return path) between two requesters, e.g. a user port and a maintenance/recalibration engine. Round-robin between ports, back-pressure from the PHY, in-order read-return routing via a port-ID tag FIFO. Sits between the requesters and the PHY command port, downstream of the read-calibration mux.

## Interface
Parameters:
- p_TAG_AW, 3, log2 of tag FIFO depth (depth = 2^p_TAG_AW = 8 outstanding reads)

Ports (N = 0, 1 for each per-port line):
- i_clk_div  in  1  controller clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_pN_cmd_en  in  1  port N request, held with fields stable until ack
- i_pN_cmd_sel  in  1  0 = write, 1 = read
- i3_pN_bank / i14_pN_row / i10_pN_col  in  3/14/10  address
- i128_pN_wrdata / i8_pN_wrdm  in  128/8  write data / mask
- o_pN_cmd_ack  out  1  one-cycle pulse: port N command issued
- o_pN_rddata_valid  out  1  one-cycle pulse: read data for port N
- o128_pN_rddata  out  128  read data, valid with o_pN_rddata_valid
- i_phy_cmd_full  in  1  PHY command queue full
- o_phy_cmd_en  out  1  one-cycle command strobe
- o_phy_cmd_sel, o3_phy_bank, o14_phy_row, o10_phy_col, o128_phy_wrdata, o8_phy_wrdm  out  1/3/14/10/128/8  command fields
- i_phy_rddata_valid  in  1  PHY read data strobe
- in_phy_rddata  in  128  PHY read data
- o_err  out  1  sticky: read data returned with no outstanding tag
- o_busy  out  1  outstanding reads > 0

## Operation
- Grant eligibility for port N: i_pN_cmd_en, !i_phy_cmd_full, no ack pulse in current cycle, and (write, or tag FIFO not full).
- Both eligible: grant port ≠ r_last; one eligible: grant it; update r_last to granted port. r_last resets to 1 (port 0 wins first tie).
- On grant (edge k): registered outputs in cycle k+1: o_phy_cmd_en = 1, o_pN_cmd_ack = 1, PHY fields = granted port's fields. Fields hold last granted value while o_phy_cmd_en = 0.
- No grant in any cycle with an ack high, so a held request is never issued twice; max rate one command per 2 cycles.
- Read grant pushes port ID into tag FIFO at the same edge. Writes push nothing.
- i_phy_rddata_valid pops FIFO head; next cycle o_pH_rddata_valid = 1 and o128_pH_rddata = captured data, for head port H. Other port's valid stays 0; its data output holds its last value.
- Pop with FIFO empty: data dropped, no valid pulse, o_err set until reset.
- Simultaneous push and pop: both performed, count unchanged. Pop on empty with simultaneous push: error case above, push still performed (no bypass).
- Count width p_TAG_AW+1; full at 2^p_TAG_AW; pointers wrap modulo depth.
- o_busy = (count != 0), combinational from count register.

## Timing
- Reset values: all outputs 0, o_phy fields 0, count/pointers 0, r_last = 1, o_err = 0.
- Reset mid-operation: outstanding tags discarded; data returning after reset raises o_err.
- Request-to-issue latency: 1 cycle (request seen at edge k, strobe/ack in cycle k+1).
- i_phy_cmd_full sampled only at grant edge; assertion during the strobe cycle does not cancel it.
- Read-return latency through block: 1 cycle.
- Command i_pN_* inputs need not be stable after ack cycle.

## Test plan
- Reset, then port 0 write (bank 3, row 0x0100, col 0x008) -> cycle after request: o_phy_cmd_en = 1, o_p0_cmd_ack = 1, fields match, sel = 0; count stays 0.
- Both ports request reads continuously -> strobes every 2nd cycle, order P0,P1,P0,P1; return 4 data words -> valids routed P0,P1,P0,P1 in order, data intact.
- Port 1 issues 8 reads with no returns -> 9th read not acked, o_busy = 1; port 0 write still granted; one return frees slot, 9th read acked next eligible cycle.
- i_phy_cmd_full = 1 for 5 cycles with port 0 pending -> no strobe; deassert -> strobe 1 cycle after deassert sampled.
- i_phy_rddata_valid with empty FIFO -> no port valid, o_err = 1 and stays 1 until i_rst.
- Reset asserted with 3 reads outstanding -> count 0, o_busy = 0; subsequent return sets o_err.

Source files
------------

// File: rtl/ddr3_cmd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_cmd_arb
//  Purpose  : Two-port round-robin arbiter in front of the DDR3 PHY command
//             port. Read grants push the port ID into a tag FIFO so returning
//             read data is routed back to the port that issued the read.
//  Revision : 1.0  initial release
// ============================================================================
module ddr3_cmd_arb #(
  parameter int p_TAG_AW = 3
) (
  input  logic         i_clk_div,
  input  logic         i_rst,
  // port 0
  input  logic         i_p0_cmd_en,
  input  logic         i_p0_cmd_sel,
  input  logic [2:0]   i3_p0_bank,
  input  logic [13:0]  i14_p0_row,
  input  logic [9:0]   i10_p0_col,
  input  logic [127:0] i128_p0_wrdata,
  input  logic [7:0]   i8_p0_wrdm,
  output logic         o_p0_cmd_ack,
  output logic         o_p0_rddata_valid,
  output logic [127:0] o128_p0_rddata,
  // port 1
  input  logic         i_p1_cmd_en,
  input  logic         i_p1_cmd_sel,
  input  logic [2:0]   i3_p1_bank,
  input  logic [13:0]  i14_p1_row,
  input  logic [9:0]   i10_p1_col,
  input  logic [127:0] i128_p1_wrdata,
  input  logic [7:0]   i8_p1_wrdm,
  output logic         o_p1_cmd_ack,
  output logic         o_p1_rddata_valid,
  output logic [127:0] o128_p1_rddata,
  // PHY command port
  input  logic         i_phy_cmd_full,
  output logic         o_phy_cmd_en,
  output logic         o_phy_cmd_sel,
  output logic [2:0]   o3_phy_bank,
  output logic [13:0]  o14_phy_row,
  output logic [9:0]   o10_phy_col,
  output logic [127:0] o128_phy_wrdata,
  output logic [7:0]   o8_phy_wrdm,
  // PHY read return
  input  logic         i_phy_rddata_valid,
  input  logic [127:0] in_phy_rddata,
  // status
  output logic         o_err,
  output logic         o_busy
);

  localparam int                c_DEPTH   = 1 << p_TAG_AW;
  localparam logic [p_TAG_AW:0] c_FULL    = {1'b1, {p_TAG_AW{1'b0}}};
  localparam logic [p_TAG_AW:0] c_CNT_ONE = {{p_TAG_AW{1'b0}}, 1'b1};
  localparam logic [p_TAG_AW-1:0] c_PTR_ONE = {{(p_TAG_AW-1){1'b0}}, 1'b1};

  // registered state
  logic                cmd_en_q,  cmd_en_d;
  logic                ack0_q,    ack0_d;
  logic                ack1_q,    ack1_d;
  logic                sel_q,     sel_d;
  logic [2:0]          bank_q,    bank_d;
  logic [13:0]         row_q,     row_d;
  logic [9:0]          col_q,     col_d;
  logic [127:0]        wd_q,      wd_d;
  logic [7:0]          dm_q,      dm_d;
  logic                last_q,    last_d;
  logic [c_DEPTH-1:0]  tag_q,     tag_d;
  logic [p_TAG_AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [p_TAG_AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [p_TAG_AW:0]   count_q,   count_d;
  logic                rdv0_q,    rdv0_d;
  logic                rdv1_q,    rdv1_d;
  logic [127:0]        rdd0_q,    rdd0_d;
  logic [127:0]        rdd1_q,    rdd1_d;
  logic                err_q,     err_d;

  // combinational helpers
  logic w_ack_any, w_tag_full, w_tag_empty;
  logic w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic w_push, w_pop, w_head;

  // Arbitration, tag FIFO bookkeeping and read-return routing
  always_comb begin
    cmd_en_d = 1'b0;
    sel_d    = sel_q;
    bank_d   = bank_q;
    row_d    = row_q;
    col_d    = col_q;
    wd_d     = wd_q;
    dm_d     = dm_q;
    last_d   = last_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdd0_d   = rdd0_q;
    rdd1_d   = rdd1_q;
    err_d    = err_q;

    // An ack in flight blocks all grants so a held request is never reissued.
    w_ack_any   = ack0_q | ack1_q;
    w_tag_full  = (count_q == c_FULL);
    w_tag_empty = (count_q == '0);

    w_elig0 = i_p0_cmd_en & ~i_phy_cmd_full & ~w_ack_any & (~i_p0_cmd_sel | ~w_tag_full);
    w_elig1 = i_p1_cmd_en & ~i_phy_cmd_full & ~w_ack_any & (~i_p1_cmd_sel | ~w_tag_full);

    // On a tie the port that did not win last time gets the grant.
    w_gnt0 = w_elig0 & (~w_elig1 | last_q);
    w_gnt1 = w_elig1 & (~w_elig0 | ~last_q);

    ack0_d = w_gnt0;
    ack1_d = w_gnt1;

    if (w_gnt0) begin
      cmd_en_d = 1'b1;
      last_d   = 1'b0;
      sel_d    = i_p0_cmd_sel;
      bank_d   = i3_p0_bank;
      row_d    = i14_p0_row;
      col_d    = i10_p0_col;
      wd_d     = i128_p0_wrdata;
      dm_d     = i8_p0_wrdm;
    end else if (w_gnt1) begin
      cmd_en_d = 1'b1;
      last_d   = 1'b1;
      sel_d    = i_p1_cmd_sel;
      bank_d   = i3_p1_bank;
      row_d    = i14_p1_row;
      col_d    = i10_p1_col;
      wd_d     = i128_p1_wrdata;
      dm_d     = i8_p1_wrdm;
    end

    w_push = (w_gnt0 & i_p0_cmd_sel) | (w_gnt1 & i_p1_cmd_sel);
    // Empty-FIFO returns are never bypassed from a same-edge push.
    w_pop  = i_phy_rddata_valid & ~w_tag_empty;
    w_head = tag_q[rd_ptr_q];

    if (w_push) begin
      tag_d[wr_ptr_q] = w_gnt1;
      wr_ptr_d        = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase

    rdv0_d = w_pop & ~w_head;
    rdv1_d = w_pop &  w_head;
    if (rdv0_d) rdd0_d = in_phy_rddata;
    if (rdv1_d) rdd1_d = in_phy_rddata;

    if (i_phy_rddata_valid & w_tag_empty) err_d = 1'b1;
  end

  // State register with synchronous reset; last winner resets to port 1
  always_ff @(posedge i_clk_div) begin
    if (i_rst) begin
      cmd_en_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      sel_q    <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      wd_q     <= '0;
      dm_q     <= '0;
      last_q   <= 1'b1;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdv0_q   <= 1'b0;
      rdv1_q   <= 1'b0;
      rdd0_q   <= '0;
      rdd1_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cmd_en_q <= cmd_en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      sel_q    <= sel_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wd_q     <= wd_d;
      dm_q     <= dm_d;
      last_q   <= last_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdv0_q   <= rdv0_d;
      rdv1_q   <= rdv1_d;
      rdd0_q   <= rdd0_d;
      rdd1_q   <= rdd1_d;
      err_q    <= err_d;
    end
  end

  assign o_phy_cmd_en      = cmd_en_q;
  assign o_phy_cmd_sel     = sel_q;
  assign o3_phy_bank       = bank_q;
  assign o14_phy_row       = row_q;
  assign o10_phy_col       = col_q;
  assign o128_phy_wrdata   = wd_q;
  assign o8_phy_wrdm       = dm_q;
  assign o_p0_cmd_ack      = ack0_q;
  assign o_p1_cmd_ack      = ack1_q;
  assign o_p0_rddata_valid = rdv0_q;
  assign o_p1_rddata_valid = rdv1_q;
  assign o128_p0_rddata    = rdd0_q;
  assign o128_p1_rddata    = rdd1_q;
  assign o_err             = err_q;
  assign o_busy            = (count_q != '0);

endmodule
`default_nettype wire
